// File: rtl/pulse_pkg.sv
// Shared widths, pulse entry layout and sequencer states for the pulse
// playback path between the pulse register FIFO and the CORDIC/DAC stream.
package pulse_pkg;

  localparam int ACC_W      = 32;
  localparam int AMP_W      = 16;
  localparam int TSTART_W   = 32;
  localparam int TLEN_W     = 16;
  localparam int ENV_ADDR_W = 10;

  typedef struct packed {
    logic [ACC_W-1:0]      freq;
    logic [ACC_W-1:0]      phase;
    logic [AMP_W-1:0]      amp;
    logic [TSTART_W-1:0]   tstart;
    logic [TLEN_W-1:0]     tlen;
    logic [ENV_ADDR_W-1:0] env_addr;
  } pulse_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PLAY
  } seq_state_t;

endpackage

// File: rtl/phase_accumulator.sv
// Loadable wrapping phase accumulator: load takes priority over a step by
// the increment; the sum wraps naturally at the accumulator width.
module phase_accumulator
  import pulse_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [ACC_W-1:0] load_value,
  input  logic [ACC_W-1:0] increment,
  output logic [ACC_W-1:0] acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_value;
    end else if (enable) begin
      acc <= acc + increment;
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// Pops pulse entries, waits for the time counter to reach t_start, then
// streams t_len samples of phase/amplitude/envelope address downstream.
module pulse_sequencer
  import pulse_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TSTART_W-1:0]   counter,
  input  logic                  pr_empty,
  output logic                  pr_rd_en,
  input  logic [ACC_W-1:0]      pr_freq,
  input  logic [ACC_W-1:0]      pr_phase,
  input  logic [AMP_W-1:0]      pr_amp,
  input  logic [TSTART_W-1:0]   pr_tstart,
  input  logic [TLEN_W-1:0]     pr_tlen,
  input  logic [ENV_ADDR_W-1:0] pr_env_addr,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ACC_W-1:0]      m_phase,
  output logic [AMP_W-1:0]      m_amp,
  output logic [ENV_ADDR_W-1:0] m_env_addr,
  output logic                  m_last,
  output logic                  busy,
  output logic                  pulse_done,
  output logic                  late_err,
  output logic                  underrun_err,
  input  logic                  clr_err
);

  seq_state_t                   state, state_next;
  pulse_entry_t                 entry, pr_entry;
  logic [ENV_ADDR_W-1:0]        idx;
  logic [TLEN_W-1:0]            remaining;
  logic signed [TSTART_W-1:0]   diff;
  logic                         pop, acc_load, late_set, underrun_set;
  logic                         handshake, is_last;

  assign pr_entry = '{freq:     pr_freq,
                      phase:    pr_phase,
                      amp:      pr_amp,
                      tstart:   pr_tstart,
                      tlen:     pr_tlen,
                      env_addr: pr_env_addr};

  // Signed view of the modular distance keeps the comparison correct across counter wrap
  assign diff         = entry.tstart - counter;
  assign handshake    = m_valid & m_ready;
  assign is_last      = (remaining == TLEN_W'(1));
  assign underrun_set = m_valid & ~m_ready;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    acc_load   = 1'b0;
    pulse_done = 1'b0;
    late_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!pr_empty) begin
          pop        = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (entry.tlen == '0) begin
          pulse_done = 1'b1;
          state_next = IDLE;
        end else if (diff == 1) begin
          acc_load   = 1'b1;
          state_next = PLAY;
        end else if (diff <= 0) begin
          late_set   = 1'b1;
          acc_load   = 1'b1;
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (m_ready && is_last) begin
          pulse_done = 1'b1;
          if (!pr_empty) begin
            pop        = 1'b1;
            state_next = WAIT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The entry is overwritten on the chaining pop while the last sample is still on the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry <= '0;
    end else if (pop) begin
      entry <= pr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      remaining <= '0;
    end else if (acc_load) begin
      idx       <= '0;
      remaining <= entry.tlen;
    end else if (handshake) begin
      idx       <= idx + ENV_ADDR_W'(1);
      remaining <= remaining - TLEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      late_err     <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      if (late_set) begin
        late_err <= 1'b1;
      end else if (clr_err) begin
        late_err <= 1'b0;
      end
      if (underrun_set) begin
        underrun_err <= 1'b1;
      end else if (clr_err) begin
        underrun_err <= 1'b0;
      end
    end
  end

  phase_accumulator u_phase_acc (
    .clk        (clk),
    .rst        (rst),
    .load       (acc_load),
    .enable     (handshake),
    .load_value (entry.phase),
    .increment  (entry.freq),
    .acc        (m_phase)
  );

  assign pr_rd_en   = pop & ~rst;
  assign m_valid    = (state == PLAY);
  assign m_amp      = entry.amp;
  assign m_env_addr = entry.env_addr + idx;
  assign m_last     = m_valid & is_last;
  assign busy       = (state != IDLE);

endmodule
